id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk input 1 (system clock, rising edge); rst input 1 (asynchronous, active-high reset).
REQ-002 SHALL have upstream handshake: in_valid input 1 (decoded instruction present); in_ready output 1 (stage can accept).
REQ-003 SHALL have decode inputs:
- rd1, rd2 input 32 (register-file read data)
- imm16 input 16
- rs, rt, rd input 5
- funct input 6
- aluop input 2
- alusrc, regdst, regwrite, memread, memwrite, memtoreg, branch input 1 each
REQ-004 SHALL have flush input 1 (squash held and incoming instruction).
REQ-005 SHALL have downstream handshake: out_valid output 1; out_ready input 1.
REQ-006 SHALL have execute-side outputs:
- a, b output 32 (ALU operands)
- control output 3 (ALU control)
- store_data output 32
- wreg output 5
- regwrite_q, memread_q, memwrite_q, memtoreg_q, branch_q output 1 each

Function
REQ-007 SHALL drive in_ready = !out_valid || out_ready (combinational).
REQ-008 SHALL capture all inputs on the rising clk edge where in_valid && in_ready && !flush, and set out_valid=1 on that edge.
REQ-009 SHALL clear out_valid when out_ready=1 and no capture occurs on the same edge; when out_ready=1 and a capture occurs, the entry is replaced with no bubble (latency 1 cycle, throughput 1/cycle).
REQ-010 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-011 SHALL, on an edge with flush=1, clear out_valid and drop any simultaneous capture; flush dominates the handshake.
REQ-012 SHALL force regwrite_q, memread_q, memwrite_q and branch_q to 0 on every edge that leaves out_valid=0.
REQ-013 SHALL register a = rd1 (after forwarding, REQ-019).
REQ-014 SHALL register b from one of two sources:
- alusrc=1: imm16 sign-extended to 32 bits
- alusrc=0: rd2 (after forwarding)
REQ-015 SHALL register store_data = rd2 (after forwarding), independent of alusrc.
REQ-016 SHALL register wreg = rd when regdst=1, else rt.
REQ-017 SHALL register control decoded from aluop/funct:
- aluop 00 -> 010
- aluop 01 -> 110
- aluop 11 -> 011
- aluop 10 -> by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->011

Reset
REQ-018 SHALL, while rst=1 and independent of clk, hold all outputs at 0; on deassertion, in_ready=1.

Configuration
REQ-019 SHALL, with FORWARD_EN defined:
- add inputs exmem_regwrite 1, exmem_rd 5, exmem_result 32, memwb_regwrite 1, memwb_rd 5, memwb_result 32
- at capture, substitute the rs and rt operands from these sources: exmem_result if exmem_regwrite && exmem_rd==reg && reg!=0; else memwb_result under the same conditions; else the register-file value
- EX/MEM has priority over MEM/WB; register 0 is never forwarded
REQ-020 SHALL, without FORWARD_EN, omit the forwarding ports and use rd1/rd2 directly.

Structure
REQ-021 SHALL take ALU control codes (ADD 010, SUB 110, AND 000, OR 001, SLT 111, X 011), aluop encodings and funct constants from a shared package mips_pkg, also used by the ALU.
REQ-022 SHALL implement REQ-017 in a combinational sub-module alu_control (inputs aluop, funct; output control).

Verification
REQ-023 Bench SHALL cover the following directed scenarios:
- R-type add: aluop=10, funct=100000, rd1=5, rd2=7, regdst=1, rd=3 -> next edge out_valid=1, a=5, b=7, control=010, wreg=3.
- lw: aluop=00, alusrc=1, imm16=16'hFFFC, rd1=100 -> b=32'hFFFFFFFC, control=010, wreg=rt, memread_q=1.
- Backpressure: out_valid=1, out_ready=0, in_valid=1 -> in_ready=0, outputs unchanged over 3 cycles; out_ready=1 -> next instruction loaded with no bubble.
- Flush during capture: in_valid=1, in_ready=1, flush=1 -> next edge out_valid=0, regwrite_q=0, memwrite_q=0.
- FORWARD_EN priority: rs=rt=4, exmem_rd=4 (result 11), memwb_rd=4 (result 22), both regwrite=1 -> a=11, store_data=11; repeat with rs=0 -> a=rd1.
- Async reset mid-operation: rst asserted between clk edges with out_valid=1 -> out_valid=0 and all outputs 0 immediately; undefined funct=111111 with aluop=10 -> control=011.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS constants: ALU control codes, aluop encodings, funct
// values, and the ID/EX register bundle. Used by id_ex_stage and ALU.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_X   = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_X   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] store_data;
    logic [2:0]  control;
    logic [4:0]  wreg;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        branch;
  } id_ex_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_ex_stage_alu_control.sv
// ALU control decoder: aluop + funct -> 3-bit ALU control code.
// Ports: aluop[1:0], funct[5:0] in; control[2:0] out. Combinational.
module alu_control
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] control
);

  always_comb begin
    control = ALU_X;
    unique case (aluop)
      ALUOP_MEM: control = ALU_ADD;
      ALUOP_BR:  control = ALU_SUB;
      ALUOP_X:   control = ALU_X;
      ALUOP_R: begin
        case (funct)
          FUNCT_ADD: control = ALU_ADD;
          FUNCT_SUB: control = ALU_SUB;
          FUNCT_AND: control = ALU_AND;
          FUNCT_OR:  control = ALU_OR;
          FUNCT_SLT: control = ALU_SLT;
          default:   control = ALU_X;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush, and
// optional operand forwarding (macro FORWARD_EN).
// Ports: clk, rst(async high); in_valid/in_ready; decode inputs
// rd1 rd2 imm16 rs rt rd funct aluop and control bits; flush;
// out_valid/out_ready; a b control store_data wreg, *_q control.
// FORWARD_EN adds exmem_* and memwb_* forwarding inputs.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [15:0] imm16,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [1:0]  aluop,
  input  logic        alusrc,
  input  logic        regdst,
  input  logic        regwrite,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        memtoreg,
  input  logic        branch,
  input  logic        flush,
`ifdef FORWARD_EN
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  control,
  output logic [31:0] store_data,
  output logic [4:0]  wreg,
  output logic        regwrite_q,
  output logic        memread_q,
  output logic        memwrite_q,
  output logic        memtoreg_q,
  output logic        branch_q
);

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  ctl;
  logic        valid;
  logic        cap;
  id_ex_t      nxt;
  id_ex_t      q;

`ifdef FORWARD_EN
  // EX/MEM wins over MEM/WB; $zero is never forwarded
  function automatic logic [31:0] fwd(
    input logic [4:0]  r,
    input logic [31:0] rf
  );
    if (exmem_regwrite && exmem_rd == r && r != 5'd0)
      return exmem_result;
    else if (memwb_regwrite && memwb_rd == r && r != 5'd0)
      return memwb_result;
    else
      return rf;
  endfunction

  assign op_a = fwd(rs, rd1);
  assign op_b = fwd(rt, rd2);
`else
  logic unused_rs;
  assign unused_rs = ^rs;
  assign op_a = rd1;
  assign op_b = rd2;
`endif

  alu_control u_alu_control (
    .aluop   (aluop),
    .funct   (funct),
    .control (ctl)
  );

  always_comb begin
    nxt            = '0;
    nxt.a          = op_a;
    nxt.b          = alusrc ? sext16(imm16) : op_b;
    nxt.store_data = op_b;
    nxt.control    = ctl;
    nxt.wreg       = regdst ? rd : rt;
    nxt.regwrite   = regwrite;
    nxt.memread    = memread;
    nxt.memwrite   = memwrite;
    nxt.memtoreg   = memtoreg;
    nxt.branch     = branch;
  end

  // gated by rst so every output reads 0 while reset is held
  assign in_ready = !rst && (!valid || out_ready);
  assign cap = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (flush || !cap) begin
      // keep a stalled entry; otherwise the slot empties and
      // side-effecting control bits must not linger
      if (flush || out_ready || !valid) begin
        valid      <= 1'b0;
        q.regwrite <= 1'b0;
        q.memread  <= 1'b0;
        q.memwrite <= 1'b0;
        q.branch   <= 1'b0;
      end
    end else begin
      valid <= 1'b1;
      q     <= nxt;
    end
  end

  assign out_valid  = valid;
  assign a          = q.a;
  assign b          = q.b;
  assign control    = q.control;
  assign store_data = q.store_data;
  assign wreg       = q.wreg;
  assign regwrite_q = q.regwrite;
  assign memread_q  = q.memread;
  assign memwrite_q = q.memwrite;
  assign memtoreg_q = q.memtoreg;
  assign branch_q   = q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
// Build with FORWARD_EN defined to exercise the forwarding paths.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rd1, rd2;
  logic [15:0] imm16;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [1:0]  aluop;
  logic        alusrc, regdst, regwrite, memread;
  logic        memwrite, memtoreg, branch, flush;
  logic        out_valid, out_ready;
  logic [31:0] a, b, store_data;
  logic [2:0]  control;
  logic [4:0]  wreg;
  logic        regwrite_q, memread_q, memwrite_q;
  logic        memtoreg_q, branch_q;
`ifdef FORWARD_EN
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] fn_tab [6] = '{6'b100010, 6'b100100, 6'b100101,
                             6'b101010, 6'b111111, 6'b000000};
  logic [2:0] ct_tab [6] = '{3'b110, 3'b000, 3'b001,
                             3'b111, 3'b011, 3'b011};

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rd1(rd1), .rd2(rd2), .imm16(imm16),
    .rs(rs), .rt(rt), .rd(rd),
    .funct(funct), .aluop(aluop),
    .alusrc(alusrc), .regdst(regdst),
    .regwrite(regwrite), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg),
    .branch(branch), .flush(flush),
`ifdef FORWARD_EN
    .exmem_regwrite(exmem_regwrite),
    .exmem_rd(exmem_rd),
    .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite),
    .memwb_rd(memwb_rd),
    .memwb_result(memwb_result),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .control(control),
    .store_data(store_data), .wreg(wreg),
    .regwrite_q(regwrite_q), .memread_q(memread_q),
    .memwrite_q(memwrite_q), .memtoreg_q(memtoreg_q),
    .branch_q(branch_q)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    in_valid = 0; rd1 = 0; rd2 = 0; imm16 = 0;
    rs = 0; rt = 0; rd = 0; funct = 0; aluop = 0;
    alusrc = 0; regdst = 0; regwrite = 0; memread = 0;
    memwrite = 0; memtoreg = 0; branch = 0; flush = 0;
`ifdef FORWARD_EN
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
`endif
  endtask

  initial begin
    rst = 1;
    out_ready = 0;
    clr_in();
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_a", a, 0);
    step();
    rst = 0;
    #1;
    chk("post_rst_ready", in_ready, 1);

    // R-type add
    in_valid = 1; aluop = 2'b10; funct = 6'b100000;
    rd1 = 5; rd2 = 7; regdst = 1; rd = 3; rt = 8;
    regwrite = 1;
    step();
    chk("add_valid", out_valid, 1);
    chk("add_a", a, 5);
    chk("add_b", b, 7);
    chk("add_ctl", control, 3'b010);
    chk("add_wreg", wreg, 3);
    chk("add_rw", regwrite_q, 1);

    // lw, consumes the add in the same edge
    out_ready = 1;
    clr_in();
    in_valid = 1; aluop = 2'b00; alusrc = 1;
    imm16 = 16'hFFFC; rd1 = 100; rd2 = 55;
    rt = 9; rd = 2; regwrite = 1; memread = 1; memtoreg = 1;
    step();
    chk("lw_valid", out_valid, 1);
    chk("lw_a", a, 100);
    chk("lw_b", b, 32'hFFFFFFFC);
    chk("lw_ctl", control, 3'b010);
    chk("lw_wreg", wreg, 9);
    chk("lw_mr", memread_q, 1);
    chk("lw_sd", store_data, 55);

    // backpressure with a beq waiting
    out_ready = 0;
    clr_in();
    in_valid = 1; aluop = 2'b01; rd1 = 1; rd2 = 2;
    rt = 6; branch = 1;
    #1;
    chk("bp_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_b", b, 32'hFFFFFFFC);
      chk("bp_wreg", wreg, 9);
    end
    out_ready = 1;
    #1;
    chk("bp_rel_ready", in_ready, 1);
    step();
    chk("beq_valid", out_valid, 1);
    chk("beq_ctl", control, 3'b110);
    chk("beq_a", a, 1);
    chk("beq_b", b, 2);
    chk("beq_br", branch_q, 1);
    chk("beq_mr", memread_q, 0);

    // drain: slot empties, control bits cleared
    clr_in();
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_br", branch_q, 0);

    // flush during capture
    in_valid = 1; regwrite = 1; memwrite = 1;
    rd1 = 9; aluop = 2'b00;
    flush = 1;
    #1;
    chk("fl_ready", in_ready, 1);
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_rw", regwrite_q, 0);
    chk("fl_mw", memwrite_q, 0);

    // flush of a held entry
    flush = 0; out_ready = 0;
    step();
    chk("sw_mw", memwrite_q, 1);
    in_valid = 0; flush = 1;
    step();
    chk("flh_valid", out_valid, 0);
    chk("flh_mw", memwrite_q, 0);
    chk("flh_rw", regwrite_q, 0);
    flush = 0; out_ready = 1;

    // funct decode and aluop 11
    clr_in();
    in_valid = 1; aluop = 2'b10;
    for (int i = 0; i < 6; i++) begin
      funct = fn_tab[i];
      step();
      chk("funct_ctl", control, {29'd0, ct_tab[i]});
    end
    aluop = 2'b11; funct = 6'b100000;
    step();
    chk("aluop11_ctl", control, 3'b011);

`ifdef FORWARD_EN
    clr_in();
    in_valid = 1; aluop = 2'b10; funct = 6'b100000;
    rs = 4; rt = 4; rd1 = 1; rd2 = 2;
    exmem_regwrite = 1; exmem_rd = 4; exmem_result = 11;
    memwb_regwrite = 1; memwb_rd = 4; memwb_result = 22;
    step();
    chk("fw_a", a, 11);
    chk("fw_b", b, 11);
    chk("fw_sd", store_data, 11);
    rs = 0;
    step();
    chk("fw_r0_a", a, 1);
    chk("fw_r0_sd", store_data, 11);
    rs = 4; exmem_regwrite = 0;
    step();
    chk("fw_wb_a", a, 22);
    memwb_regwrite = 0;
    step();
    chk("fw_none_a", a, 1);
    chk("fw_none_sd", store_data, 2);
`endif

    // async reset between edges with a held entry
    clr_in();
    in_valid = 1; aluop = 2'b10; funct = 6'b111111;
    rd1 = 3; rd2 = 4; rt = 7; regwrite = 1;
    out_ready = 0;
    step();
    chk("pre_valid", out_valid, 1);
    chk("undef_ctl", control, 3'b011);
    #2;
    rst = 1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_a", a, 0);
    chk("ar_b", b, 0);
    chk("ar_ctl", control, 0);
    chk("ar_wreg", wreg, 0);
    chk("ar_rw", regwrite_q, 0);
    chk("ar_ready", in_ready, 0);
    #3;
    rst = 0;
    #1;
    chk("ar_rel_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
